// File: rtl/wb_dma_if.sv
// Wishbone B4 classic bus bundle used by the DMA copy engine.
//   master modport: drives adr/dat_w/we/sel/stb/cyc, samples dat_r/ack/err
//   slave modport : the mirror image, for responders and bench models
interface wb_dma_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_dma_copy.sv
// Wishbone B4 classic DMA initiator: copies len_i 32-bit words from src_adr_i to dst_adr_i,
// one outstanding access, read-then-write per word, cyc held for the whole copy.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-low reset
//   start_i                 one-cycle request, only sampled while busy_o=0
//   src_adr_i, dst_adr_i    byte addresses, bits [1:0] ignored
//   len_i                   word count (0 gives an immediate done pulse)
//   busy_o, done_o, err_o   status: in progress, one-cycle end pulse, sticky abort flag
//   bus                     Wishbone master (wb_dma_if.master)
// Optional feature: define WB_DMA_TIMEOUT_EN to abort a beat that waits TIMEOUT_CYCLES
// cycles without ack/err.
module wb_dma_copy #(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    wb_dma_if.master         bus
);

    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone, StAbort} state_e;

    state_e           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;   // read buffer, presented directly as write data
    logic             we_q;
    logic [3:0]       sel_q;
    logic             stb_q;
    logic             cyc_q;
    logic             tmo_hit;

    // Address LSBs are dropped on purpose.
    logic unused_bits;
    assign unused_bits = ^{src_adr_i[1:0], dst_adr_i[1:0]};

`ifdef WB_DMA_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;

    // Counts edges a beat has waited; any ack or leaving the bus states restarts it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            tmo_q <= '0;
        end else if ((state_q == StRead || state_q == StWrite) && !bus.ack) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST) && !bus.ack;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // Done/abort are idle as far as start_i is concerned (busy_o is already 0).
                StIdle, StDone, StAbort: begin
                    state_q <= StIdle;
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i != '0) begin
                            src_q   <= {src_adr_i[31:2], 2'b00};
                            dst_q   <= {dst_adr_i[31:2], 2'b00};
                            cnt_q   <= len_i;
                            adr_q   <= {src_adr_i[31:2], 2'b00};
                            we_q    <= 1'b0;
                            sel_q   <= 4'hF;
                            stb_q   <= 1'b1;
                            cyc_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= StRead;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRead, StWrite: begin
                    // err beats ack when both arrive together
                    if (bus.err || tmo_hit) begin
                        state_q <= StAbort;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (bus.ack) begin
                        if (state_q == StRead) begin
                            dat_q   <= bus.dat_r;
                            adr_q   <= dst_q;
                            we_q    <= 1'b1;
                            state_q <= StWrite;
                        end else begin
                            src_q <= src_q + 32'd4;
                            dst_q <= dst_q + 32'd4;
                            cnt_q <= cnt_q - 1'b1;
                            if (cnt_q == LEN_W'(1)) begin
                                state_q <= StDone;
                                cyc_q   <= 1'b0;
                                stb_q   <= 1'b0;
                                we_q    <= 1'b0;
                                sel_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                // stb stays high: next beat starts on this same edge
                                adr_q   <= src_q + 32'd4;
                                we_q    <= 1'b0;
                                state_q <= StRead;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign bus.adr   = adr_q;
    assign bus.dat_w = dat_q;
    assign bus.we    = we_q;
    assign bus.sel   = sel_q;
    assign bus.stb   = stb_q;
    assign bus.cyc   = cyc_q;

endmodule

// File: tb/tb_wb_dma_copy.sv
module tb_wb_dma_copy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;

    wb_dma_if bus ();

    wb_dma_copy #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .start_i  (start),
        .src_adr_i(src),
        .dst_adr_i(dst),
        .len_i    (len),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int popped = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {bit we; logic [31:0] adr; logic [31:0] dat;} beat_t;
    typedef struct {bit err; int lat; int issue;} done_t;
    beat_t exp_beats[$];
    done_t exp_done[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Memory contents before anything is written.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- bus responder RAM ----------------
    logic [31:0] ram_mem [logic [31:0]];
    bit  rand_wait = 0;
    bit  stall = 0;
    int  inject_at = -1;
    int  beat_total = 0;
    int  wcnt = 0;
    int  wtgt = 0;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_word(a);
    endfunction

    initial begin
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.dat_r = '0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            wcnt    <= 0;
        end else if (bus.stb && bus.cyc && !bus.ack && !bus.err) begin
            if (wcnt < wtgt) begin
                wcnt <= wcnt + 1;
            end else if (!stall) begin
                wcnt <= 0;
                wtgt <= rand_wait ? int'($urandom_range(0, 2)) : 0;
                beat_total <= beat_total + 1;
                bus.ack <= 1'b1;
                if (beat_total == inject_at) begin
                    bus.err <= 1'b1;   // ack and err together
                end else if (bus.we) begin
                    ram_mem[bus.adr] = bus.dat_w;
                end else begin
                    bus.dat_r <= ram_rd(bus.adr);
                end
            end
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Ascending word copy; beat number 'fail' is the one the responder errors.
    function automatic void model_copy(input logic [31:0] s_in, input logic [31:0] d_in,
                                       input int n_words, input int fail, input int lat,
                                       input int issue);
        logic [31:0] s = s_in & ~32'h3;
        logic [31:0] d = d_in & ~32'h3;
        logic [31:0] w;
        int  n = 0;
        bit  e = 0;
        for (int i = 0; i < n_words; i++) begin
            if (n == fail) begin e = 1; break; end
            exp_beats.push_back('{we: 1'b0, adr: s, dat: 32'h0});
            n++;
            if (n == fail) begin e = 1; break; end
            w = ref_rd(s);
            exp_beats.push_back('{we: 1'b1, adr: d, dat: w});
            ref_mem[d] = w;
            n++;
            s = s + 32'd4;
            d = d + 32'd4;
        end
        exp_done.push_back('{err: e, lat: lat, issue: issue});
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        beat_t b;
        done_t d;
        if (rst_n) begin
            if (bus.stb && bus.cyc && bus.ack && !bus.err) begin
                popped++;
                if (exp_beats.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: got adr %0h we %0b required no beat",
                             bus.adr, bus.we);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_we", 128'(bus.we), 128'(b.we));
                    chk("beat_adr", 128'(bus.adr), 128'(b.adr));
                    chk("beat_sel", 128'(bus.sel), 128'(4'hF));
                    if (b.we) chk("beat_dat", 128'(bus.dat_w), 128'(b.dat));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 required 0");
                end else begin
                    d = exp_done.pop_front();
                    chk("done_err", 128'(err), 128'(d.err));
                    chk("done_busy_cyc_stb", 128'({busy, bus.cyc, bus.stb}), 128'(0));
                    if (d.lat >= 0) chk("done_lat", 128'(cyc_cnt - d.issue - 1), 128'(d.lat));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n_words,
                         input int fail, input int lat);
        @(negedge clk);
        model_copy(s, d, n_words, fail, lat, cyc_cnt);
        src = s; dst = d; len = 16'(n_words); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string nm, input int limit);
        int n = 0;
        while (exp_done.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({nm, "_done_seen"}, 128'(exp_done.size()), 128'(0));
        chk({nm, "_beats_left"}, 128'(exp_beats.size()), 128'(0));
        exp_done.delete();
        exp_beats.delete();
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_ctl"}, 128'({busy, done, err, bus.stb, bus.cyc, bus.we, bus.sel}), 128'(0));
        chk({nm, "_adr_dat"}, 128'({bus.adr, bus.dat_w}), 128'(0));
    endtask

    initial begin
        logic [31:0] rs, rd;
        int rl, n;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // 1: four words, 1-cycle-ack memory, 16 cycles to done
        issue(32'h100, 32'h200, 4, -1, 16);
        wait_quiet("t1", 100);
        for (int i = 0; i < 4; i++) chk("t1_ram", 128'(ram_rd(32'h200 + 4 * i)), 128'(32'hA0 + i));

        // 2: zero length
        issue(32'h100, 32'h200, 0, -1, 0);
        chk("t2_busy_cyc", 128'({busy, bus.cyc}), 128'(0));
        wait_quiet("t2", 10);

        // 3: unaligned addresses
        issue(32'h103, 32'h201, 1, -1, 4);
        wait_quiet("t3", 50);

        // 4: responder error on the second write
        inject_at = beat_total + 3;
        issue(32'h300, 32'h400, 3, 3, -1);
        wait_quiet("t4", 100);
        inject_at = -1;
        repeat (2) @(negedge clk);
        chk("t4_err_sticky", 128'(err), 128'(1));
        chk("t4_word0", 128'(ram_rd(32'h400)), 128'(init_word(32'h300)));
        chk("t4_word1", 128'(ram_rd(32'h404)), 128'(init_word(32'h404)));

        // 5: reset in the middle of a read, then a fresh copy
        issue(32'h8000, 32'h9000, 8, -1, -1);
        n = 0;
        while (!(popped >= 2 && bus.stb && !bus.we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("t5_reached_read", 128'(bus.stb && !bus.we), 128'(1));
        exp_beats.delete();
        exp_done.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("t5_reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(32'h104, 32'h20C, 2, -1, 8);
        wait_quiet("t5_fresh", 50);

`ifdef WB_DMA_TIMEOUT_EN
        // 6: responder never acks
        stall = 1;
        issue(32'h500, 32'h600, 2, 0, 8);
        wait_quiet("t6", 50);
        stall = 0;
`endif

        // address wrap at the top of the space
        issue(32'hFFFF_FFF8, 32'h2000, 3, -1, 12);
        wait_quiet("wrap_src", 60);
        issue(32'h3000, 32'hFFFF_FFFC, 2, -1, 8);
        wait_quiet("wrap_dst", 60);

        // randomized copies with wait states, overlapping regions and ignored busy starts
        rand_wait = 1;
        for (int t = 0; t < 14; t++) begin
            rs = 32'h1000 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            rd = 32'h1000 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            rl = $urandom_range(0, 6);
            issue(rs, rd, rl, -1, -1);
            if (rl != 0) begin
                src = 32'h7000; dst = 32'h7100; len = 16'd5; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_quiet("rand", 200);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
